// File: rtl/peak_tracker_if.sv
// Session control, sample stream and peak-result bundle for peak_tracker.
interface peak_tracker_if #(
  parameter int DATA_W   = 12,
  parameter int NUM_AXES = 2,
  parameter int POS_W    = 32,
  parameter int CNT_W    = 16
);
  logic                      start;
  logic                      stop;
  logic                      smp_vld;
  logic [DATA_W-1:0]         smp_val;
  logic [NUM_AXES*POS_W-1:0] pos;
  logic [DATA_W-1:0]         max_val;
  logic [NUM_AXES*POS_W-1:0] max_pos;
  logic                      new_max;
  logic                      done;
  logic                      busy;
  logic [CNT_W-1:0]          smp_cnt;

  modport master (
    output start, stop, smp_vld, smp_val, pos,
    input  max_val, max_pos, new_max, done, busy, smp_cnt
  );

  modport slave (
    input  start, stop, smp_vld, smp_val, pos,
    output max_val, max_pos, new_max, done, busy, smp_cnt
  );
endinterface

// File: rtl/peak_tracker.sv
// Scan-session peak hold: keeps the largest ADC sample (with hysteresis) and the servo
// pulse widths at that peak. Optional window averaging of candidates via `define PEAK_AVG_EN.
module peak_tracker #(
  parameter int DATA_W      = 12,
  parameter int NUM_AXES    = 2,
  parameter int POS_W       = 32,
  parameter int THRESH      = 4,
  parameter int MAX_SAMPLES = 0,
  parameter int CNT_W       = 16,
  parameter int AVG_LOG2    = 2
) (
  input logic          clk,
  input logic          rst,
  peak_tracker_if.slave bus
);
  localparam int PW = NUM_AXES * POS_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] max_val_q;
  logic [PW-1:0]     max_pos_q;
  logic              new_max_q;
  logic              done_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              seen_q;

  logic              scan_smp;
  logic [DATA_W-1:0] cand;
  logic              cand_vld;
  logic              accept;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              auto_stop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Limit is formed one bit wider so a peak near full scale cannot wrap the band.
  function automatic logic beats_peak(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] p);
    logic [DATA_W:0] lim;
    lim = {1'b0, p} + (DATA_W+1)'(THRESH);
    return {1'b0, c} > lim;
  endfunction

  // A sample coinciding with START is dropped, since START restarts the session.
  assign scan_smp = (state == SCAN) && bus.smp_vld && !bus.start;

`ifdef PEAK_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] win_q;
  logic                win_last;

  assign acc_sum  = acc_q + ACC_W'(bus.smp_val);
  assign win_last = &win_q;
  assign cand     = DATA_W'(acc_sum >> AVG_LOG2);
  assign cand_vld = scan_smp && win_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      win_q <= '0;
    end else if (bus.start) begin
      acc_q <= '0;
      win_q <= '0;
    end else if (scan_smp) begin
      acc_q <= win_last ? '0 : acc_sum;
      win_q <= win_q + AVG_LOG2'(1);
    end
  end
`else
  assign cand     = bus.smp_val;
  assign cand_vld = scan_smp;
`endif

  assign accept    = cand_vld && (!seen_q || beats_peak(cand, max_val_q));
  assign cnt_nxt   = sat_inc(cnt_q);
  assign auto_stop = (MAX_SAMPLES != 0) && (cnt_nxt == CNT_W'(MAX_SAMPLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      max_val_q <= '0;
      max_pos_q <= '0;
      new_max_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      new_max_q <= 1'b0;
      done_q    <= 1'b0;
      if (bus.start) begin
        state     <= SCAN;
        busy_q    <= 1'b1;
        max_val_q <= '0;
        max_pos_q <= '0;
        cnt_q     <= '0;
        seen_q    <= 1'b0;
      end else if (state == SCAN) begin
        if (scan_smp) cnt_q <= cnt_nxt;
        if (accept) begin
          max_val_q <= cand;
          max_pos_q <= bus.pos;
          new_max_q <= 1'b1;
          seen_q    <= 1'b1;
        end
        // The sample sharing this cycle with STOP is still processed above.
        if (bus.stop || (scan_smp && auto_stop)) begin
          state  <= HOLD;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.max_val = max_val_q;
  assign bus.max_pos = max_pos_q;
  assign bus.new_max = new_max_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.smp_cnt = cnt_q;
endmodule

// File: tb/tb_peak_tracker.sv
// Scoreboard bench for peak_tracker: two instances (free-running and auto-stop at 3).
module tb_peak_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  peak_tracker_if #(.DATA_W(12), .NUM_AXES(2), .POS_W(32), .CNT_W(16)) ia ();
  peak_tracker_if #(.DATA_W(12), .NUM_AXES(2), .POS_W(32), .CNT_W(16)) ib ();

  peak_tracker #(.DATA_W(12), .NUM_AXES(2), .POS_W(32), .THRESH(4), .MAX_SAMPLES(0),
                 .CNT_W(16), .AVG_LOG2(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  peak_tracker #(.DATA_W(12), .NUM_AXES(2), .POS_W(32), .THRESH(4), .MAX_SAMPLES(3),
                 .CNT_W(16), .AVG_LOG2(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  typedef struct {
    logic [11:0] val;
    logic [63:0] pos;
    logic        nm;
    logic        dn;
    logic [15:0] cnt;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [11:0] v, input logic [31:0] h, input logic [31:0] vp,
                             input logic nm, input logic dn, input logic [15:0] c);
    ev_t e;
    e.val = v; e.pos = {vp, h}; e.nm = nm; e.dn = dn; e.cnt = c;
    return e;
  endfunction

  // Monitors: every NEW_MAX or DONE pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (ia.new_max || ia.done)) begin
      ev_t e;
      if (qa.size() == 0) begin
        chk("a_unexpected_event", {62'd0, ia.new_max, ia.done}, 64'd0);
      end else begin
        e = qa.pop_front();
        chk("a_max_val", ia.max_val, e.val);
        chk("a_max_pos", ia.max_pos, e.pos);
        chk("a_new_max", ia.new_max, e.nm);
        chk("a_done", ia.done, e.dn);
        chk("a_smp_cnt", ia.smp_cnt, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (ib.new_max || ib.done)) begin
      ev_t e;
      if (qb.size() == 0) begin
        chk("b_unexpected_event", {62'd0, ib.new_max, ib.done}, 64'd0);
      end else begin
        e = qb.pop_front();
        chk("b_max_val", ib.max_val, e.val);
        chk("b_max_pos", ib.max_pos, e.pos);
        chk("b_new_max", ib.new_max, e.nm);
        chk("b_done", ib.done, e.dn);
        chk("b_smp_cnt", ib.smp_cnt, e.cnt);
      end
    end
  end

  task automatic drive(input bit sel, input logic st, input logic sp, input logic vld,
                       input logic [11:0] val, input logic [31:0] h, input logic [31:0] v);
    if (!sel) begin
      ia.start = st; ia.stop = sp; ia.smp_vld = vld; ia.smp_val = val; ia.pos = {v, h};
    end else begin
      ib.start = st; ib.stop = sp; ib.smp_vld = vld; ib.smp_val = val; ib.pos = {v, h};
    end
    @(posedge clk); #1;
    if (!sel) begin
      ia.start = 0; ia.stop = 0; ia.smp_vld = 0; ia.smp_val = '0; ia.pos = '0;
    end else begin
      ib.start = 0; ib.stop = 0; ib.smp_vld = 0; ib.smp_val = '0; ib.pos = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_max_val"}, ia.max_val, 0);
    chk({tag, "_max_pos"}, ia.max_pos, 0);
    chk({tag, "_new_max"}, ia.new_max, 0);
    chk({tag, "_done"}, ia.done, 0);
    chk({tag, "_busy"}, ia.busy, 0);
    chk({tag, "_smp_cnt"}, ia.smp_cnt, 0);
  endtask

  initial begin
    ia.start = 0; ia.stop = 0; ia.smp_vld = 0; ia.smp_val = '0; ia.pos = '0;
    ib.start = 0; ib.stop = 0; ib.smp_vld = 0; ib.smp_val = '0; ib.pos = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_zero_a("reset");
    chk("reset_b_busy", ib.busy, 0);
    rst = 0;
    idle(1);

`ifndef PEAK_AVG_EN
    // Basic update and hysteresis
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("t1_busy", ia.busy, 1);
    qa.push_back(mk(100, 10, 7, 1, 0, 1));
    drive(0, 0, 0, 1, 100, 10, 7);
    drive(0, 0, 0, 1, 103, 11, 7);
    qa.push_back(mk(105, 12, 7, 1, 0, 3));
    drive(0, 0, 0, 1, 105, 12, 7);
    drive(0, 0, 0, 1, 104, 13, 7);
    idle(1);
    chk("t1_max_val", ia.max_val, 105);
    chk("t1_max_pos", ia.max_pos, {32'd7, 32'd12});
    chk("t1_smp_cnt", ia.smp_cnt, 4);

    // Band limit computed without wrap near full scale
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("t2_cleared", ia.max_val, 0);
    qa.push_back(mk(4093, 1, 2, 1, 0, 1));
    drive(0, 0, 0, 1, 4093, 1, 2);
    drive(0, 0, 0, 1, 4095, 3, 4);
    idle(1);
    chk("t2_max_val", ia.max_val, 4093);
    chk("t2_max_pos", ia.max_pos, {32'd2, 32'd1});

    // STOP with sample, HOLD behaviour, START/STOP collision, bare STOP
    drive(0, 1, 0, 0, 0, 0, 0);
    qa.push_back(mk(500, 5, 5, 1, 0, 1));
    drive(0, 0, 0, 1, 500, 5, 5);
    qa.push_back(mk(700, 6, 9, 1, 1, 2));
    drive(0, 0, 1, 1, 700, 6, 9);
    chk("t4_busy", ia.busy, 0);
    drive(0, 0, 0, 1, 900, 8, 8);
    idle(1);
    chk("t4_hold_val", ia.max_val, 700);
    chk("t4_hold_cnt", ia.smp_cnt, 2);
    drive(0, 1, 1, 0, 0, 0, 0);
    chk("t4_restart_busy", ia.busy, 1);
    chk("t4_restart_val", ia.max_val, 0);
    qa.push_back(mk(0, 0, 0, 0, 1, 0));
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("t4_stop_busy", ia.busy, 0);

    // Auto-stop after three samples
    drive(1, 1, 0, 0, 0, 0, 0);
    qb.push_back(mk(1, 1, 1, 1, 0, 1));
    drive(1, 0, 0, 1, 1, 1, 1);
    qb.push_back(mk(50, 2, 1, 1, 0, 2));
    drive(1, 0, 0, 1, 50, 2, 1);
    qb.push_back(mk(60, 3, 1, 1, 1, 3));
    drive(1, 0, 0, 1, 60, 3, 1);
    drive(1, 0, 0, 1, 900, 4, 1);
    idle(1);
    chk("t3_busy", ib.busy, 0);
    chk("t3_max_val", ib.max_val, 60);
    chk("t3_smp_cnt", ib.smp_cnt, 3);
`else
    // Window-averaged candidates, partial window discarded at STOP
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 10, 1, 7);
    drive(0, 0, 0, 1, 20, 2, 7);
    drive(0, 0, 0, 1, 30, 3, 7);
    qa.push_back(mk(25, 4, 7, 1, 0, 4));
    drive(0, 0, 0, 1, 40, 4, 7);
    drive(0, 0, 0, 1, 80, 5, 7);
    drive(0, 0, 0, 1, 90, 6, 7);
    qa.push_back(mk(25, 4, 7, 0, 1, 6));
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    chk("t6_max_val", ia.max_val, 25);
    chk("t6_smp_cnt", ia.smp_cnt, 6);
`endif

    // Asynchronous reset in the middle of a scan
    drive(0, 1, 0, 0, 0, 0, 0);
    qa.push_back(mk(300, 10, 7, 1, 0, 1));
    drive(0, 0, 0, 1, 300, 10, 7);
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk_zero_a("async_rst");
    @(posedge clk); #1;
    rst = 0;
    drive(0, 0, 0, 1, 999, 1, 1);
    idle(1);
    chk("post_rst_busy", ia.busy, 0);
    chk("post_rst_val", ia.max_val, 0);

    idle(2);
    chk("a_pending_events", qa.size(), 0);
    chk("b_pending_events", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
